// File: rtl/def.sv
// Shared definitions for the instruction encoder: format encoding,
// major opcode constants and the buffered entry layout.
package def;

    // Instruction format selector; codes 6 and 7 are not legal formats.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_format_t;

    // Major opcodes of the base ISA plus the atomic extension.
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_AMO    = 7'h2F;

    // Every 32-bit (uncompressed) opcode ends in 2'b11.
    localparam logic [1:0] OPCODE_LSBS = 2'b11;

    // One buffered result: the encoded word plus its reject flag.
    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } fifo_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry buffer of encoded words with a valid/ready style push/pop.
// Pointers wrap modulo DEPTH; count runs 0..DEPTH.
module instr_fifo
    import def::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output fifo_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_entry_t      mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    // Advance a pointer, wrapping explicitly so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer or a pop from an empty one is silently dropped.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the buffer without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
        if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields back into a 32-bit word, flags
// requests whose fields cannot be represented, and buffers the results.
module instr_encoder
    import def::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  instr_format_t fmt,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   instr_raw,
    output logic          out_err
);

    logic        ready_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    fifo_entry_t head;
    fifo_entry_t enc_entry;
    logic [31:0] enc_word;
    logic        enc_legal;

    // The immediate must be the sign-extension of the field width the format stores.
    logic imm_fits12;
    logic imm_fits13;
    logic imm_fits21;

    assign imm_fits12 = (imm[31:11] == {21{imm[11]}});
    assign imm_fits13 = (imm[31:12] == {20{imm[12]}});
    assign imm_fits21 = (imm[31:20] == {12{imm[20]}});

    // Format packing and legality check; rejected requests become a zero word with err set.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                enc_word  = {imm[11:0], rs1, funct3, rd, opcode};
                enc_legal = imm_fits12;
            end
            FMT_S: begin
                enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_legal = imm_fits12;
            end
            FMT_B: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_legal = imm_fits13 && !imm[0];
            end
            FMT_U: begin
                enc_word  = {imm[31:12], rd, opcode};
                enc_legal = (imm[11:0] == 12'h0);
            end
            FMT_J: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_legal = imm_fits21 && !imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
        if (opcode[1:0] != OPCODE_LSBS) enc_legal = 1'b0;
        enc_entry.word = enc_legal ? enc_word : 32'h0;
        enc_entry.err  = !enc_legal;
    end

    // Holds req_ready low through reset and for the edge on which reset releases.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    assign req_ready = ready_q && !fifo_full;
    assign push      = req_valid && req_ready;

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .entry_i (enc_entry),
        .pop_i   (out_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Outputs are forced to zero whenever the buffer is empty, including during reset.
    assign out_valid = !fifo_empty;
    assign instr_raw = out_valid ? head.word : 32'h0;
    assign out_err   = out_valid && head.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, rejects,
// backpressure, asynchronous reset, and a randomized run against a
// range-arithmetic reference model with a queue of expected entries.
module tb_instr_encoder;
    import def::*;

    localparam int DEPTH = 2;

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    instr_format_t fmt;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr_raw;
    logic          out_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          f;
        int          op;
        int          f3;
        int          f7;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } exp_t;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_raw (instr_raw),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: legality from the signed value range of the immediate, word
    // assembled by shifting each field to its bit position.
    function automatic exp_t ref_encode(input req_t r);
        exp_t e;
        int   s;
        int   w;
        bit   ok;
        s  = $signed(r.imm);
        ok = ((r.op % 4) == 3);
        w  = 0;
        case (r.f)
            0: w = (r.f7 << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | r.op;
            1: begin
                ok = ok && (s >= -2048) && (s <= 2047);
                w  = ((s & 'hFFF) << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | r.op;
            end
            2: begin
                ok = ok && (s >= -2048) && (s <= 2047);
                w  = (((s >> 5) & 'h7F) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
                   | ((s & 'h1F) << 7) | r.op;
            end
            3: begin
                ok = ok && (s >= -4096) && (s <= 4095) && ((s & 1) == 0);
                w  = (((s >> 12) & 1) << 31) | (((s >> 5) & 'h3F) << 25) | (r.rs2 << 20) | (r.rs1 << 15)
                   | (r.f3 << 12) | (((s >> 1) & 'hF) << 8) | (((s >> 11) & 1) << 7) | r.op;
            end
            4: begin
                ok = ok && ((s % 4096) == 0);
                w  = (s & 32'hFFFFF000) | (r.rd << 7) | r.op;
            end
            5: begin
                ok = ok && (s >= -1048576) && (s <= 1048575) && ((s & 1) == 0);
                w  = (((s >> 20) & 1) << 31) | (((s >> 1) & 'h3FF) << 21) | (((s >> 11) & 1) << 20)
                   | (((s >> 12) & 'hFF) << 12) | (r.rd << 7) | r.op;
            end
            default: ok = 1'b0;
        endcase
        e.word = ok ? 32'(w) : 32'h0;
        e.err  = !ok;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   bnd [8] = '{2047, 2048, -2048, -2049, 4094, 4096, 1048574, -1048576};
        r.f   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
        r.op  = int'($urandom_range(0, 127));
        if ($urandom_range(0, 5) != 0) r.op = r.op | 3;
        r.f3  = int'($urandom_range(0, 7));
        r.f7  = int'($urandom_range(0, 127));
        r.rd  = int'($urandom_range(0, 31));
        r.rs1 = int'($urandom_range(0, 31));
        r.rs2 = int'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0:       r.imm = $urandom;
            1:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       r.imm = $urandom & 32'hFFFFF000;
            3:       r.imm = (32'($urandom_range(0, 2097151)) - 32'h100000) & ~32'h1;
            4:       r.imm = 32'(bnd[$urandom_range(0, 7)]);
            default: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
        return r;
    endfunction

    task automatic drive(input req_t r);
        req_valid = 1'b1;
        fmt       = instr_format_t'(3'(r.f));
        opcode    = 7'(r.op);
        funct3    = 3'(r.f3);
        funct7    = 7'(r.f7);
        rd        = 5'(r.rd);
        rs1       = 5'(r.rs1);
        rs2       = 5'(r.rs2);
        imm       = r.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 1'b0;
        out_ready = 1'b0;
        fmt = FMT_R; opcode = '0; funct3 = '0; funct7 = '0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        rstn = 1'b0;
        #3;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b expected 0", out_err);
        else n_pass++;
        n_checks++;
        if (instr_raw !== 32'h0) $display("FAIL reset_instr_raw: got %h expected 00000000", instr_raw);
        else n_pass++;
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready: got %b expected 1", req_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    // Legal encodings back to back with the consumer always ready; unused fields carry junk.
    task automatic test_encodings();
        req_t        v [6];
        logic [31:0] w [6];
        v[0] = '{f:1, op:'h13, f3:0, f7:127, rd:1,  rs1:0,  rs2:31, imm:32'h5};        w[0] = 32'h00500093;
        v[1] = '{f:2, op:'h23, f3:2, f7:127, rd:31, rs1:1,  rs2:2,  imm:32'h8};        w[1] = 32'h0020A423;
        v[2] = '{f:3, op:'h63, f3:0, f7:127, rd:31, rs1:0,  rs2:0,  imm:32'hFFFFFFFC}; w[2] = 32'hFE000EE3;
        v[3] = '{f:4, op:'h37, f3:7, f7:127, rd:5,  rs1:31, rs2:31, imm:32'h12345000}; w[3] = 32'h123452B7;
        v[4] = '{f:5, op:'h6F, f3:7, f7:127, rd:1,  rs1:31, rs2:31, imm:32'h800};      w[4] = 32'h001000EF;
        v[5] = '{f:0, op:'h33, f3:0, f7:'h20, rd:1, rs1:2,  rs2:3,  imm:32'hFFFFFFFF}; w[5] = 32'h403100B3;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(v[i]);
            n_checks++;
            if (req_ready !== 1'b1) $display("FAIL enc_req_ready[%0d]: got %b expected 1", i, req_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || instr_raw !== w[i] || out_err !== 1'b0)
                $display("FAIL enc_word[%0d]: got v=%b %h err=%b expected v=1 %h err=0",
                         i, out_valid, instr_raw, out_err, w[i]);
            else n_pass++;
        end
        req_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL enc_drained: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    // Each reject rule in turn, then a legal request to show rejects do not stick.
    task automatic test_rejects();
        req_t v [8];
        v[0] = '{f:1, op:'h13, f3:0, f7:0, rd:1, rs1:0, rs2:0, imm:32'h800};
        v[1] = '{f:3, op:'h63, f3:0, f7:0, rd:0, rs1:0, rs2:0, imm:32'h3};
        v[2] = '{f:6, op:'h13, f3:0, f7:0, rd:1, rs1:0, rs2:0, imm:32'h5};
        v[3] = '{f:1, op:'h12, f3:0, f7:0, rd:1, rs1:0, rs2:0, imm:32'h5};
        v[4] = '{f:4, op:'h37, f3:0, f7:0, rd:5, rs1:0, rs2:0, imm:32'h12345001};
        v[5] = '{f:5, op:'h6F, f3:0, f7:0, rd:1, rs1:0, rs2:0, imm:32'h801};
        v[6] = '{f:2, op:'h23, f3:2, f7:0, rd:0, rs1:1, rs2:2, imm:32'hFFFFF7FF};
        v[7] = '{f:1, op:'h13, f3:0, f7:0, rd:1, rs1:0, rs2:0, imm:32'hFFFFF800};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ew;
            logic        ee;
            ew = (i == 7) ? 32'h80000093 : 32'h0;
            ee = (i != 7);
            drive(v[i]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || instr_raw !== ew || out_err !== ee)
                $display("FAIL reject[%0d]: got v=%b %h err=%b expected v=1 %h err=%b",
                         i, out_valid, instr_raw, out_err, ew, ee);
            else n_pass++;
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        req_t a, b, c;
        exp_t ea, eb;
        a = '{f:1, op:'h13, f3:int'($urandom_range(0, 7)), f7:0, rd:int'($urandom_range(1, 31)),
              rs1:int'($urandom_range(0, 31)), rs2:0, imm:32'($urandom_range(0, 2047))};
        b = '{f:0, op:'h33, f3:int'($urandom_range(0, 7)), f7:int'($urandom_range(0, 127)),
              rd:int'($urandom_range(0, 31)), rs1:int'($urandom_range(0, 31)),
              rs2:int'($urandom_range(0, 31)), imm:32'h0};
        c = '{f:4, op:'h37, f3:0, f7:0, rd:7, rs1:0, rs2:0, imm:32'hABCDE000};
        ea = ref_encode(a);
        eb = ref_encode(b);
        out_ready = 1'b0;
        drive(a);
        tick();
        drive(b);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_ready_after_1: got %b expected 1", req_ready);
        else n_pass++;
        tick();
        drive(c);
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL bp_ready_after_2: got %b expected 0", req_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || instr_raw !== ea.word) $display("FAIL bp_head_a: got %b %h expected 1 %h", out_valid, instr_raw, ea.word);
        else n_pass++;
        tick();
        n_checks++;
        if (req_ready !== 1'b0 || instr_raw !== ea.word || out_err !== ea.err)
            $display("FAIL bp_hold: got rdy=%b %h err=%b expected rdy=0 %h err=%b", req_ready, instr_raw, out_err, ea.word, ea.err);
        else n_pass++;
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || instr_raw !== eb.word || req_ready !== 1'b1)
            $display("FAIL bp_drain_b: got v=%b %h rdy=%b expected v=1 %h rdy=1", out_valid, instr_raw, req_ready, eb.word);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req_t a, d;
        exp_t ed;
        a  = '{f:1, op:'h03, f3:2, f7:0, rd:4, rs1:5, rs2:0, imm:32'h10};
        d  = '{f:2, op:'h23, f3:int'($urandom_range(0, 7)), f7:0, rd:0, rs1:int'($urandom_range(0, 31)),
               rs2:int'($urandom_range(0, 31)), imm:32'($urandom_range(0, 4095)) - 32'd2048};
        ed = ref_encode(d);
        out_ready = 1'b0;
        drive(a);
        tick();
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL rm_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, req_ready);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || instr_raw !== 32'h0 || out_err !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL rm_async: got v=%b %h err=%b rdy=%b expected all zero", out_valid, instr_raw, out_err, req_ready);
        else n_pass++;
        #2 rstn = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rm_release: got rdy=%b v=%b expected rdy=1 v=0", req_ready, out_valid);
        else n_pass++;
        drive(d);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || instr_raw !== ed.word || out_err !== ed.err)
            $display("FAIL rm_first: got v=%b %h err=%b expected v=1 %h err=%b", out_valid, instr_raw, out_err, ed.word, ed.err);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rm_sole: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    // Random traffic on both sides, scored against a queue of expected entries.
    task automatic test_random();
        exp_t q [$];
        req_t r;
        bit   exp_rdy;
        bit   do_pop;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = rand_req();
            drive(r);
            req_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            exp_rdy   = (q.size() < DEPTH);
            n_checks++;
            if (req_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, req_ready, exp_rdy);
            else n_pass++;
            n_checks++;
            if (out_valid !== (q.size() != 0)) $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, out_valid, q.size() != 0);
            else n_pass++;
            if (q.size() != 0) begin
                n_checks++;
                if (instr_raw !== q[0].word || out_err !== q[0].err)
                    $display("FAIL rnd_head[%0d]: got %h err=%b expected %h err=%b", cyc, instr_raw, out_err, q[0].word, q[0].err);
                else n_pass++;
            end
            do_pop = (q.size() != 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (req_valid && exp_rdy) q.push_back(ref_encode(r));
            tick();
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rnd_drain: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_rejects();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
